// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcodes and datapath control encodings for mc_control
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXEC,
        S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JR, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_AND   = 3'b101;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [2:0] BT_BEQ  = 3'b100;
    localparam logic [2:0] BT_BGEZ = 3'b110;
    localparam logic [2:0] BT_BGTZ = 3'b010;
    localparam logic [2:0] BT_BLEZ = 3'b101;
    localparam logic [2:0] BT_BLTZ = 3'b001;
    localparam logic [2:0] BT_BNE  = 3'b111;

    // instruction-class one-hot bit positions
    localparam int C_LW  = 0;
    localparam int C_SW  = 1;
    localparam int C_R   = 2;
    localparam int C_JR  = 3;
    localparam int C_IMM = 4;
    localparam int C_BR  = 5;
    localparam int C_J   = 6;
    localparam int C_JAL = 7;
    localparam int C_W   = 8;

    function automatic logic [2:0] branch_type_of(input logic [5:0] op, input logic [4:0] rt);
        return op == OP_BNE    ? BT_BNE  :
               op == OP_BLEZ   ? BT_BLEZ :
               op == OP_BGTZ   ? BT_BGTZ :
               op == OP_REGIMM ? (rt == RT_BGEZ ? BT_BGEZ : BT_BLTZ) : BT_BEQ;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: opcode/funct/rt to instruction-class one-hot; EXT_BRANCH_EN adds bne/blez/bgtz/bltz/bgez
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]     i_opcode,
    input  logic [5:0]     i_funct,
    input  logic [4:0]     i_rt,
    output logic [C_W-1:0] o_cls
);

`ifdef EXT_BRANCH_EN
    localparam logic EXT = 1'b1;
`else
    localparam logic EXT = 1'b0;
`endif

    logic w_rtype;
    logic w_ext_br;

    // classify the instruction; an all-zero class vector means unsupported
    always_comb begin
        w_rtype        = i_opcode == OP_RTYPE;
        w_ext_br       = (i_opcode inside {OP_BNE, OP_BLEZ, OP_BGTZ}) ||
                         (i_opcode == OP_REGIMM && (i_rt inside {RT_BLTZ, RT_BGEZ}));
        o_cls          = '0;
        o_cls[C_LW]    = i_opcode == OP_LW;
        o_cls[C_SW]    = i_opcode == OP_SW;
        o_cls[C_R]     = w_rtype && i_funct != FN_JR;
        o_cls[C_JR]    = w_rtype && i_funct == FN_JR;
        o_cls[C_IMM]   = i_opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
        o_cls[C_BR]    = i_opcode == OP_BEQ || (EXT && w_ext_br);
        o_cls[C_J]     = i_opcode == OP_J;
        o_cls[C_JAL]   = i_opcode == OP_JAL;
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM with memory ready/timeout and sticky trap; EXT_BRANCH_EN enables extended branches
module mc_control
    import mc_pkg::*;
#(
    parameter  int MEM_TIMEOUT = 15,
    localparam int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [2:0] branch_type,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       trap,
    output logic [3:0] state_o
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [C_W-1:0]   w_cls;
    logic             w_timeout;

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .i_rt     (rt),
        .o_cls    (w_cls)
    );

    assign w_timeout = r_cnt == CNT_W'(MEM_TIMEOUT);
    assign state_o   = r_state;

    // state sequencing; the wait counter is zero except while a memory access stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_cnt <= '0;
            case (r_state)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (mem_ready)
                        r_state <= r_state == S_FETCH  ? S_DECODE :
                                   r_state == S_MEM_RD ? S_MEM_WB : S_FETCH;
                    else if (w_timeout)
                        r_state <= S_TRAP;
                    else
                        r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DECODE:
                    r_state <= (w_cls[C_LW] || w_cls[C_SW]) ? S_MEM_ADDR :
                               w_cls[C_R]                   ? S_R_EXEC   :
                               w_cls[C_JR]                  ? S_JR       :
                               w_cls[C_IMM]                 ? S_I_EXEC   :
                               w_cls[C_BR]                  ? S_BRANCH   :
                               (w_cls[C_J] || w_cls[C_JAL]) ? S_JUMP     : S_TRAP;
                S_MEM_ADDR: r_state <= w_cls[C_LW] ? S_MEM_RD : S_MEM_WR;
                S_R_EXEC:   r_state <= S_R_WB;
                S_I_EXEC:   r_state <= S_I_WB;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // datapath controls from the current state; only the FETCH IR/PC load follows mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_type   = 3'b000;
        pc_source     = PCS_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = RD_RT;
        mem_to_reg    = MTR_ALUOUT;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        trap          = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM4;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = MTR_MDR;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = RD_RD;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_ADD;
            end
            S_I_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
                branch_type   = branch_type_of(opcode, rt);
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                reg_write  = w_cls[C_JAL];
                reg_dst    = w_cls[C_JAL] ? RD_RA : RD_RT;
                mem_to_reg = w_cls[C_JAL] ? MTR_PC : MTR_ALUOUT;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PCS_RS;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: CPI/trap vector table, directed corner sequences and randomized reference-model comparison for mc_control
module tb_mc_control;

    localparam int TMO = 4;
`ifdef EXT_BRANCH_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    // phases numbered in the order the states are listed
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEM_ADDR = 2, P_MEM_RD = 3, P_MEM_WB = 4;
    localparam int P_MEM_WR = 5, P_R_EXEC = 6, P_R_WB = 7, P_I_EXEC = 8, P_I_WB = 9;
    localparam int P_BRANCH = 10, P_JUMP = 11, P_JR = 12, P_TRAP = 13;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_JR = 3, K_IMM = 4, K_BR = 5, K_JMP = 6, K_ILL = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic [4:0] rt = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, trap;
    logic [2:0] branch_type, alu_op;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0] state_o;
    logic [26:0] got;

    int n_chk = 0;
    int n_err = 0;
    int ph[$];

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        int         cpi;
        bit         trap;
    } vec_t;
    vec_t tbl[17];
    logic [5:0] pool[16];

    mc_control #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_type(branch_type),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .trap(trap), .state_o(state_o)
    );

    assign got = {pc_write, pc_write_cond, branch_type, pc_source, iord, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, trap, state_o};

    always #5 clk = ~clk;

    function automatic int klass(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
        case (op)
            6'h00:               return fn == 6'h08 ? K_JR : K_R;
            6'h23:               return K_LW;
            6'h2b:               return K_SW;
            6'h08, 6'h0c, 6'h0d: return K_IMM;
            6'h02, 6'h03:        return K_JMP;
            6'h04:               return K_BR;
            6'h05, 6'h06, 6'h07: return EXT ? K_BR : K_ILL;
            6'h01:               return (EXT && r < 5'd2) ? K_BR : K_ILL;
            default:             return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] btype(input logic [5:0] op, input logic [4:0] r);
        case (op)
            6'h05:   return 3'b111;
            6'h06:   return 3'b101;
            6'h07:   return 3'b010;
            6'h01:   return r == 5'd1 ? 3'b110 : 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    // expected output vector for one cycle of a phase, from the per-state output lists
    function automatic logic [26:0] exp_out(input int p, input bit rdy);
        logic pw, pwc, io, mr, mw, irw, rw, sa, tr;
        logic [2:0] bt, ao;
        logic [1:0] ps, rd, mtr, sb;
        {pw, pwc, io, mr, mw, irw, rw, sa, tr} = '0;
        {bt, ao, ps, rd, mtr, sb} = '0;
        case (p)
            P_FETCH:    begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            P_DECODE:   sb = 2'b11;
            P_MEM_ADDR: begin sa = 1; sb = 2'b10; end
            P_MEM_RD:   begin mr = 1; io = 1; end
            P_MEM_WB:   begin rw = 1; mtr = 2'b01; end
            P_MEM_WR:   begin mw = 1; io = 1; end
            P_R_EXEC:   begin sa = 1; ao = 3'b010; end
            P_R_WB:     begin rw = 1; rd = 2'b01; end
            P_I_EXEC:   begin sa = 1; sb = 2'b10; ao = opcode == 6'h0c ? 3'b101 : opcode == 6'h0d ? 3'b100 : 3'b000; end
            P_I_WB:     rw = 1;
            P_BRANCH:   begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; bt = btype(opcode, rt); end
            P_JUMP:     begin pw = 1; ps = 2'b10; if (opcode == 6'h03) begin rw = 1; rd = 2'b10; mtr = 2'b10; end end
            P_JR:       begin pw = 1; ps = 2'b11; end
            default:    tr = 1;
        endcase
        return {pw, pwc, bt, ps, io, mr, mw, irw, rd, mtr, rw, sa, sb, ao, tr, 4'(p)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        n_chk++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, g, e);
        end
    endtask

    task automatic build(input int k);
        ph.delete();
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        case (k)
            K_LW:    begin ph.push_back(P_MEM_ADDR); ph.push_back(P_MEM_RD); ph.push_back(P_MEM_WB); end
            K_SW:    begin ph.push_back(P_MEM_ADDR); ph.push_back(P_MEM_WR); end
            K_R:     begin ph.push_back(P_R_EXEC); ph.push_back(P_R_WB); end
            K_JR:    ph.push_back(P_JR);
            K_IMM:   begin ph.push_back(P_I_EXEC); ph.push_back(P_I_WB); end
            K_BR:    ph.push_back(P_BRANCH);
            K_JMP:   ph.push_back(P_JUMP);
            default: ;
        endcase
    endtask

    task automatic step(input int p, input bit rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
        chk($sformatf("ph%0d_op%02h", p, opcode), 32'(got), 32'(exp_out(p, rdy)));
    endtask

    task automatic reset_now();
        #1;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("reset", 32'(got), 32'(exp_out(P_FETCH, 1'b0)));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_now();
    endtask

    // run one instruction; wf/wm are wait cycles before mem_ready in FETCH and in the data access
    task automatic run_model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r,
                             input int wf, input int wm, output bit trapped);
        int k;
        opcode = op;
        funct = fn;
        rt = r;
        k = klass(op, fn, r);
        build(k);
        trapped = (k == K_ILL);
        foreach (ph[i]) begin
            if (ph[i] inside {P_FETCH, P_MEM_RD, P_MEM_WR}) begin
                int w;
                w = (ph[i] == P_FETCH) ? wf : wm;
                for (int c = 0; c <= TMO; c++) begin
                    step(ph[i], c == w);
                    if (c == w) break;
                end
                if (w > TMO) begin
                    trapped = 1'b1;
                    break;
                end
            end else begin
                step(ph[i], 1'($urandom_range(0, 1)));
            end
        end
        if (trapped) repeat (2) step(P_TRAP, 1'($urandom_range(0, 1)));
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 11);
        return r < 5 ? 0 : r == 11 ? TMO + 1 : $urandom_range(1, TMO);
    endfunction

    initial begin
        bit tr;
        tbl[0]  = '{6'h00, 6'h20, 5'd0, 4, 1'b0};
        tbl[1]  = '{6'h00, 6'h08, 5'd0, 3, 1'b0};
        tbl[2]  = '{6'h23, 6'h00, 5'd0, 5, 1'b0};
        tbl[3]  = '{6'h2b, 6'h00, 5'd0, 4, 1'b0};
        tbl[4]  = '{6'h08, 6'h00, 5'd0, 4, 1'b0};
        tbl[5]  = '{6'h0c, 6'h00, 5'd0, 4, 1'b0};
        tbl[6]  = '{6'h0d, 6'h00, 5'd0, 4, 1'b0};
        tbl[7]  = '{6'h04, 6'h00, 5'd0, 3, 1'b0};
        tbl[8]  = '{6'h02, 6'h00, 5'd0, 3, 1'b0};
        tbl[9]  = '{6'h03, 6'h00, 5'd0, 3, 1'b0};
        tbl[10] = '{6'h05, 6'h00, 5'd0, EXT ? 3 : 2, !EXT};
        tbl[11] = '{6'h06, 6'h00, 5'd0, EXT ? 3 : 2, !EXT};
        tbl[12] = '{6'h07, 6'h00, 5'd0, EXT ? 3 : 2, !EXT};
        tbl[13] = '{6'h01, 6'h00, 5'd0, EXT ? 3 : 2, !EXT};
        tbl[14] = '{6'h01, 6'h00, 5'd1, EXT ? 3 : 2, !EXT};
        tbl[15] = '{6'h01, 6'h00, 5'd2, 2, 1'b1};
        tbl[16] = '{6'h3f, 6'h00, 5'd0, 2, 1'b1};
        pool = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h0c, 6'h0d, 6'h04,
                 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03, 6'h3f, 6'h10};

        do_reset();
        run_model(6'h00, 6'h20, 5'd0, 0, 0, tr);
        run_model(6'h23, 6'h00, 5'd0, 0, 3, tr);
        chk("lw_wait_no_trap", 32'(trap), 32'(0));
        run_model(6'h03, 6'h00, 5'd0, 0, 0, tr);
        run_model(6'h01, 6'h00, 5'd1, 0, 0, tr);
        if (tr) do_reset();
        run_model(6'h3f, 6'h00, 5'd0, 0, 0, tr);
        do_reset();
        run_model(6'h00, 6'h20, 5'd0, TMO + 1, 0, tr);
        chk("fetch_timeout_trap", 32'(trap), 32'(1));
        do_reset();
        run_model(6'h23, 6'h00, 5'd0, TMO, TMO, tr);
        run_model(6'h2b, 6'h00, 5'd0, 0, TMO + 1, tr);
        do_reset();

        opcode = 6'h2b;
        funct = '0;
        rt = '0;
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b0);
        step(P_MEM_ADDR, 1'b1);
        step(P_MEM_WR, 1'b0);
        reset_now();

        foreach (tbl[i]) begin
            int cyc;
            bit done;
            do_reset();
            opcode = tbl[i].op;
            funct = tbl[i].fn;
            rt = tbl[i].rt;
            cyc = 0;
            done = 1'b0;
            for (int k = 0; k < 12 && !done; k++) begin
                @(negedge clk);
                mem_ready = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
                done = (state_o == 4'(P_FETCH)) || trap;
            end
            chk($sformatf("cpi_%0d_op%02h", i, tbl[i].op), 32'(cyc), 32'(tbl[i].cpi));
            chk($sformatf("trap_%0d_op%02h", i, tbl[i].op), 32'(trap), 32'(tbl[i].trap));
        end

        do_reset();
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op, fn;
            logic [4:0] r;
            op = pool[$urandom_range(0, 15)];
            if ($urandom_range(0, 19) == 0) op = 6'($urandom_range(0, 63));
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
            r = 5'($urandom_range(0, 3));
            run_model(op, fn, r, pick_wait(), pick_wait(), tr);
            if (tr) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
